voice_mixer: RTL and testbench

Downstream of the three-voice note player: takes the three per-voice 16-bit signed sine samples plus their shared ready strobe and produces one mixed 16-bit signed sample for the codec. Only voices flagged active are summed. The sum is scaled by the active-voice count and saturated to 16 bits. A two-stage registered pipeline carries a valid strobe, and a saturating clip counter is provided for debug.

---
 rtl/voice_mixer_if.sv | 31 +++
 rtl/voice_mixer.sv | 93 +++++++++
 tb/tb_voice_mixer.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/voice_mixer_if.sv
// Sample bus between the note player, the mixer and the codec side:
// three voice samples with their active mask and strobe in, one mixed sample out.
interface voice_mixer_if;
  logic signed [15:0] sample_in1;
  logic signed [15:0] sample_in2;
  logic signed [15:0] sample_in3;
  logic               sample_in_valid;
  logic [2:0]         voice_active;
  logic signed [15:0] sample_out;
  logic               sample_out_valid;

  modport master (
    output sample_in1,
    output sample_in2,
    output sample_in3,
    output sample_in_valid,
    output voice_active,
    input  sample_out,
    input  sample_out_valid
  );

  modport slave (
    input  sample_in1,
    input  sample_in2,
    input  sample_in3,
    input  sample_in_valid,
    input  voice_active,
    output sample_out,
    output sample_out_valid
  );
endinterface

// File: rtl/voice_mixer.sv
// Three-voice mixer: masked sum, gain by active-voice count, 16-bit saturation,
// two registered stages carrying a valid strobe, plus a saturating clip counter.
module voice_mixer #(
  parameter int CLIP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  voice_mixer_if.slave      mix,
  input  logic              clip_clear,
  output logic [CLIP_W-1:0] clip_count
);
  localparam logic signed [17:0] SAT_MAX = 18'sd32767;
  localparam logic signed [17:0] SAT_MIN = -18'sd32768;

  logic signed [17:0] sum_next;
  logic [1:0]         n_next;
  logic signed [17:0] sum1;
  logic [1:0]         n1;
  logic               v1;
  logic signed [17:0] scaled;
  logic signed [15:0] clamped;
  logic               clip;

  function automatic logic signed [17:0] voice_term(input logic signed [15:0] s,
                                                    input logic en);
    return en ? $signed({{2{s[15]}}, s}) : 18'sd0;
  endfunction

  always_comb begin
    sum_next = voice_term(mix.sample_in1, mix.voice_active[0])
             + voice_term(mix.sample_in2, mix.voice_active[1])
             + voice_term(mix.sample_in3, mix.voice_active[2]);
    n_next   = {1'b0, mix.voice_active[0]}
             + {1'b0, mix.voice_active[1]}
             + {1'b0, mix.voice_active[2]};
  end

  // Mask is captured only with the strobe; sum and count hold between strobes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      v1   <= 1'b0;
      sum1 <= '0;
      n1   <= '0;
    end else begin
      v1 <= mix.sample_in_valid;
      if (mix.sample_in_valid) begin
        sum1 <= sum_next;
        n1   <= n_next;
      end
    end
  end

  // Three voices use an 11/32 gain so a full-scale chord lands just above clip.
  always_comb begin
    scaled = '0;
    case (n1)
      2'd0:    scaled = '0;
      2'd1:    scaled = sum1;
      2'd2:    scaled = sum1 >>> 1;
      default: scaled = (sum1 >>> 2) + (sum1 >>> 4) + (sum1 >>> 5);
    endcase
  end

  always_comb begin
    clip    = 1'b0;
    clamped = scaled[15:0];
    if (scaled > SAT_MAX) begin
      clamped = 16'sh7FFF;
      clip    = 1'b1;
    end else if (scaled < SAT_MIN) begin
      clamped = 16'sh8000;
      clip    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mix.sample_out       <= '0;
      mix.sample_out_valid <= 1'b0;
      clip_count           <= '0;
    end else begin
      mix.sample_out_valid <= v1;
      if (v1) begin
        mix.sample_out <= clamped;
      end
      if (clip_clear) begin
        clip_count <= '0;
      end else if (v1 && clip && !(&clip_count)) begin
        clip_count <= clip_count + CLIP_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_voice_mixer.sv
// Bench for voice_mixer: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against an arithmetic reference model.
module tb_voice_mixer;
  localparam int CLIP_W   = 8;
  localparam int CLIP_MAX = (1 << CLIP_W) - 1;

  logic              clk;
  logic              reset;
  logic              clip_clear;
  logic [CLIP_W-1:0] clip_count;

  voice_mixer_if mif ();

  voice_mixer #(.CLIP_W(CLIP_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .mix        (mif),
    .clip_clear (clip_clear),
    .clip_count (clip_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  task automatic cmp(string name, logic signed [31:0] act, logic signed [31:0] want);
    vectors++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, want, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int floordiv(int a, int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int model_scaled(int s1, int s2, int s3, logic [2:0] act);
    int s[3];
    int sum;
    int n;
    int res;
    s[0] = s1; s[1] = s2; s[2] = s3;
    sum = 0;
    n   = 0;
    for (int i = 0; i < 3; i++) begin
      if (act[i]) begin
        sum = sum + s[i];
        n   = n + 1;
      end
    end
    case (n)
      0:       res = 0;
      1:       res = sum;
      2:       res = floordiv(sum, 2);
      default: res = floordiv(sum, 4) + floordiv(sum, 16) + floordiv(sum, 32);
    endcase
    return res;
  endfunction

  typedef struct {
    int due;
    int val;
    bit clip;
  } pend_t;

  pend_t pend[$];
  int    edge_n    = 0;
  bit    live      = 1'b0;
  bit    exp_valid = 1'b0;
  int    exp_out   = 0;
  int    exp_cnt   = 0;

  // A sample presented in the cycle ending at edge e leaves after edge e+1.
  always @(posedge clk) begin
    automatic int    e   = edge_n + 1;
    automatic int    cnt = exp_cnt;
    automatic int    raw;
    automatic pend_t p;
    edge_n <= e;
    if (!reset) begin
      pend.delete();
      live      <= 1'b1;
      exp_valid <= 1'b0;
      exp_out   <= 0;
      exp_cnt   <= 0;
    end else begin
      if (pend.size() > 0 && pend[0].due == e) begin
        p = pend.pop_front();
        exp_valid <= 1'b1;
        exp_out   <= p.val;
        if (p.clip && cnt < CLIP_MAX) cnt = cnt + 1;
      end else begin
        exp_valid <= 1'b0;
      end
      if (clip_clear) cnt = 0;
      exp_cnt <= cnt;
      if (mif.sample_in_valid) begin
        raw    = model_scaled(int'(mif.sample_in1), int'(mif.sample_in2),
                              int'(mif.sample_in3), mif.voice_active);
        p.due  = e + 1;
        p.clip = (raw > 32767) || (raw < -32768);
        p.val  = (raw > 32767) ? 32767 : ((raw < -32768) ? -32768 : raw);
        pend.push_back(p);
      end
    end
  end

  int seen[$];

  always @(negedge clk) begin
    if (live) begin
      cmp("out_valid", 32'(mif.sample_out_valid), 32'(exp_valid));
      cmp("sample_out", 32'(mif.sample_out), exp_out);
      cmp("clip_count", 32'(clip_count), exp_cnt);
      if (mif.sample_out_valid === 1'b1) seen.push_back(int'(mif.sample_out));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_in(int a, int b, int c, logic [2:0] act);
    mif.sample_in1   = 16'(a);
    mif.sample_in2   = 16'(b);
    mif.sample_in3   = 16'(c);
    mif.voice_active = act;
  endtask

  task automatic strobe(int a, int b, int c, logic [2:0] act);
    set_in(a, b, c, act);
    mif.sample_in_valid = 1'b1;
    tick();
    mif.sample_in_valid = 1'b0;
  endtask

  int want[$];

  task automatic check_seen(string name);
    cmp({name, "_count"}, 32'(seen.size()), 32'(want.size()));
    foreach (want[i]) begin
      if (i < seen.size()) cmp(name, 32'(seen[i]), 32'(want[i]));
    end
  endtask

  function automatic int rand_sample();
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom_range(0, 5))
      0:       return 32767;
      1:       return -32768;
      2:       return int'($urandom_range(0, 200)) - 100;
      default: return int'($signed(r));
    endcase
  endfunction

  // ---------------- scenarios ----------------
  initial begin
    reset      = 1'b0;
    clip_clear = 1'b0;
    set_in(16'h7FFF, 16'h7FFF, 16'h7FFF, 3'b111);
    mif.sample_in_valid = 1'b1;
    idle(3);
    reset = 1'b1;
    mif.sample_in_valid = 1'b0;
    idle(2);
    cmp("reset_clip_count", 32'(clip_count), 0);
    cmp("reset_no_output", 32'(seen.size()), 0);

    seen.delete();
    strobe(32767, 16'h1234, 32767, 3'b010);
    idle(3);
    want = '{4660};
    check_seen("single_voice");
    cmp("single_clip_count", 32'(clip_count), 0);

    seen.delete();
    strobe(1000, -3000, 12345, 3'b011);
    strobe(-1, 0, -20000, 3'b011);
    idle(3);
    want = '{-1000, -1};
    check_seen("two_voice");

    seen.delete();
    strobe(100, 200, 300, 3'b111);
    idle(3);
    want = '{205};
    check_seen("three_voice");

    seen.delete();
    strobe(32767, 32767, 32767, 3'b111);
    strobe(-32768, -32768, -32768, 3'b111);
    idle(3);
    want = '{32767, -32768};
    check_seen("three_clip");
    cmp("clip_count_two", 32'(clip_count), 2);

    // clear lands on the same edge that registers the third clip
    set_in(32767, 32767, 32767, 3'b111);
    mif.sample_in_valid = 1'b1;
    tick();
    mif.sample_in_valid = 1'b0;
    clip_clear = 1'b1;
    tick();
    clip_clear = 1'b0;
    idle(2);
    cmp("clear_beats_clip", 32'(clip_count), 0);

    seen.delete();
    for (int i = 1; i <= 4; i++) strobe(i, 0, 0, 3'b001);
    idle(3);
    want = '{1, 2, 3, 4};
    check_seen("stream");

    // sample 1 is already out when reset hits; sample 2 is still in flight
    seen.delete();
    strobe(1, 0, 0, 3'b001);
    strobe(2, 0, 0, 3'b001);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    strobe(3, 0, 0, 3'b001);
    strobe(4, 0, 0, 3'b001);
    idle(3);
    want = '{1, 3, 4};
    check_seen("stream_reset");

    set_in(32767, 32767, 32767, 3'b111);
    mif.sample_in_valid = 1'b1;
    idle(CLIP_MAX);
    mif.sample_in_valid = 1'b0;
    idle(3);
    cmp("clip_count_full", 32'(clip_count), CLIP_MAX);
    strobe(-32768, -32768, -32768, 3'b111);
    idle(3);
    cmp("clip_count_sticky", 32'(clip_count), CLIP_MAX);
    clip_clear = 1'b1;
    tick();
    clip_clear = 1'b0;
    cmp("clip_count_cleared", 32'(clip_count), 0);

    for (int c = 0; c < 3000; c++) begin
      set_in(rand_sample(), rand_sample(), rand_sample(), 3'($urandom));
      mif.sample_in_valid = ($urandom_range(0, 9) < 7);
      clip_clear          = ($urandom_range(0, 49) == 0);
      reset               = ($urandom_range(0, 99) != 0);
      tick();
    end
    reset               = 1'b1;
    clip_clear          = 1'b0;
    mif.sample_in_valid = 1'b0;
    idle(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
